// File: rtl/clk_rst_seq_pkg.sv
// rtl/clk_rst_seq_pkg.sv - shared state encoding and sizing helper for the clock/reset sequencer
package clk_rst_seq_pkg;

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } seq_state_e;

    // Smallest r with 2**r >= value; used to size counters at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: period latch, counter, enable strobe and toggle clock
module clk_div_ch
    import clk_rst_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rel,       // channel reset released in the coming cycle
    input  logic             rel_prev,  // channel reset released in the current cycle
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             clk_en,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] per_q;
    logic             act_q;     // channel was enabled in the current cycle

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] per_n;
    logic             clk_n;
    logic             stb_n;

    // A divider value of zero behaves like one so the strobe never stalls.
    assign div_eff = (div == '0) ? DIV_W'(1) : div;

    // Next counter/period/toggle: the registered strobe marks the wrap cycle,
    // so the new period is picked up exactly at the wrap edge.
    always_comb begin
        cnt_n = cnt_q;
        per_n = per_q;
        clk_n = clk_out;
        if (!rel_prev) begin
            cnt_n = '0;
            per_n = div_eff;
            clk_n = 1'b0;
        end else if (clk_en) begin
            cnt_n = '0;
            per_n = div_eff;
            clk_n = ~clk_out;
        end else if (act_q) begin
            cnt_n = cnt_q + DIV_W'(1);
        end
        stb_n = en && (cnt_n == per_n - DIV_W'(1));
    end

    // Channel state is cleared whenever its reset output is (or becomes) low.
    always_ff @(posedge clk) begin
        if (rst || !rel) begin
            cnt_q   <= '0;
            per_q   <= '0;
            act_q   <= 1'b0;
            clk_en  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt_q   <= cnt_n;
            per_q   <= per_n;
            act_q   <= en;
            clk_en  <= stb_n;
            clk_out <= clk_n;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - staggered reset sequencer, per-channel clock dividers and run-time watchdog
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int RST_HOLD = 8,
    parameter int STAGGER  = 2,
    parameter int TO_W     = 24
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  SRST_REQ_I,
    input  logic [N_CH*DIV_W-1:0] DIV_I,
    input  logic [N_CH-1:0]       EN_I,
    input  logic [TO_W-1:0]       TIMEOUT_I,
    output logic [N_CH-1:0]       CLK_EN_O,
    output logic [N_CH-1:0]       CLK_O,
    output logic [N_CH-1:0]       nRST_O,
    output logic                  READY_O,
    output logic                  TIMEOUT_O
);

    // Cycle (counted from hold start) in which the last channel is released.
    localparam int T_LAST = RST_HOLD + (N_CH - 1) * STAGGER;
    localparam int SEQ_W  = (clog2(T_LAST + 1) < 1) ? 1 : clog2(T_LAST + 1);

    seq_state_e       state_q, state_n;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_n, seq_inc;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_n;
    logic [TO_W-1:0]  to_lim_q, to_lim_n;
    logic [N_CH-1:0]  nrst_n;
    logic             ready_n;
    logic             tflag_n;

    assign seq_inc = seq_cnt_q + SEQ_W'(1);

    // Next-state logic; priority is hard reset, then soft reset, then watchdog.
    always_comb begin
        state_n   = state_q;
        seq_cnt_n = seq_cnt_q;
        to_cnt_n  = to_cnt_q;
        to_lim_n  = to_lim_q;
        nrst_n    = nRST_O;
        ready_n   = READY_O;
        tflag_n   = TIMEOUT_O;
        if (RST_I) begin
            state_n   = S_ASSERT;
            seq_cnt_n = '0;
            to_cnt_n  = '0;
            to_lim_n  = '0;
            nrst_n    = '0;
            ready_n   = 1'b0;
            tflag_n   = 1'b0;
        end else if (SRST_REQ_I) begin
            // Restart the hold window but keep the sticky expiry flag.
            state_n   = S_ASSERT;
            seq_cnt_n = '0;
            to_cnt_n  = '0;
            nrst_n    = '0;
            ready_n   = 1'b0;
        end else begin
            case (state_q)
                S_ASSERT, S_RELEASE: begin
                    seq_cnt_n = seq_inc;
                    for (int k = 0; k < N_CH; k++) begin
                        nrst_n[k] = (int'(seq_inc) >= RST_HOLD + k * STAGGER);
                    end
                    if (int'(seq_inc) >= T_LAST) begin
                        state_n  = S_RUN;
                        ready_n  = 1'b1;
                        to_cnt_n = '0;
                        to_lim_n = TIMEOUT_I;
                    end else if (int'(seq_inc) >= RST_HOLD) begin
                        state_n = S_RELEASE;
                    end else begin
                        state_n = S_ASSERT;
                    end
                end
                S_RUN: begin
                    // Expiry is caught one count before the limit, so the
                    // counter can never wrap while the watchdog is armed.
                    if (to_lim_q != '0) begin
                        if (to_cnt_q == to_lim_q - TO_W'(1)) begin
                            state_n = S_DONE;
                            nrst_n  = '0;
                            ready_n = 1'b0;
                            tflag_n = 1'b1;
                        end else begin
                            to_cnt_n = to_cnt_q + TO_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    nrst_n  = '0;
                    ready_n = 1'b0;
                end
                default: begin
                    state_n = S_ASSERT;
                    nrst_n  = '0;
                    ready_n = 1'b0;
                end
            endcase
        end
    end

    // Sequencer and watchdog registers; every output leaves a flop.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= S_ASSERT;
            seq_cnt_q <= '0;
            to_cnt_q  <= '0;
            to_lim_q  <= '0;
            nRST_O    <= '0;
            READY_O   <= 1'b0;
            TIMEOUT_O <= 1'b0;
        end else begin
            state_q   <= state_n;
            seq_cnt_q <= seq_cnt_n;
            to_cnt_q  <= to_cnt_n;
            to_lim_q  <= to_lim_n;
            nRST_O    <= nrst_n;
            READY_O   <= ready_n;
            TIMEOUT_O <= tflag_n;
        end
    end

    // Channels see the next reset value so their outputs change on the same
    // edge as nRST_O.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk      (CLK_I),
            .rst      (RST_I),
            .rel      (nrst_n[g]),
            .rel_prev (nRST_O[g]),
            .en       (EN_I[g]),
            .div      (DIV_I[g*DIV_W +: DIV_W]),
            .clk_en   (CLK_EN_O[g]),
            .clk_out  (CLK_O[g])
        );
    end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Synthesisable, parametrised successor to the bench clock/reset generator.
- Sequences per-channel active-low resets out of one global reset, with configurable hold time and staggered release.
- Generates per-channel divided clock-enable strobes and toggle clocks.
- Provides a run-time watchdog that parks the design, replacing the fixed-time finish.
- Sits at the top of each MXO2 design and feeds sub-blocks.

Parameters:
- N_CH, 4: number of output channels (1..16).
- DIV_W, 16: width of each channel divider value.
- RST_HOLD, 8: cycles all resets stay asserted after reset removal (>=1).
- STAGGER, 2: cycles between successive channel releases (0 = release all together).
- TO_W, 24: width of the timeout counter.

Ports:
- CLK_I, input, 1: single system clock; all logic is on its rising edge.
- RST_I, input, 1: reset, synchronous, active-high.
- SRST_REQ_I, input, 1: soft reset request, level-sampled each cycle.
- DIV_I, input, N_CH*DIV_W: channel k divider value in bits [k*DIV_W +: DIV_W].
- EN_I, input, N_CH: per-channel divider enable.
- TIMEOUT_I, input, TO_W: run-time limit in cycles; 0 = disabled.
- CLK_EN_O, output, N_CH: one-cycle enable strobes.
- CLK_O, output, N_CH: divided toggle clocks.
- nRST_O, output, N_CH: per-channel active-low resets.
- READY_O, output, 1: all channels released and running.
- TIMEOUT_O, output, 1: sticky watchdog expiry flag.

Behaviour:
- Reset (RST_I=1 at an edge):
  - State S_ASSERT; hold/stagger/timeout counters cleared.
  - nRST_O=0, CLK_O=0, CLK_EN_O=0, READY_O=0, TIMEOUT_O=0.
- State machine:
  - S_ASSERT: all nRST_O=0. Count RST_HOLD cycles, with cycle 0 = the first cycle RST_I is low. Then go to S_RELEASE.
  - S_RELEASE:
    - nRST_O[k] reads 1 from cycle RST_HOLD + k*STAGGER.
    - The state becomes S_RUN in the cycle the last channel is released; READY_O=1 in that same cycle.
    - TIMEOUT_I is sampled on entry to S_RUN.
  - S_RUN: dividers run; the timeout counter increments each cycle. If the sampled TIMEOUT_I != 0 and count == TIMEOUT_I-1, the next state is S_DONE.
  - S_DONE:
    - All nRST_O=0, READY_O=0, CLK_EN_O=0, CLK_O=0.
    - TIMEOUT_O=1, sticky until RST_I.
    - Exits only via RST_I or SRST_REQ_I.
- Soft reset:
  - SRST_REQ_I=1 in any state returns the block to S_ASSERT at the next edge: all channels re-asserted, hold count restarted, READY_O=0.
  - TIMEOUT_O is preserved.
  - Holding SRST_REQ_I high keeps the block in S_ASSERT.
- Priority: RST_I > SRST_REQ_I > timeout expiry. If SRST_REQ_I and expiry occur in the same cycle, the block goes to S_ASSERT and TIMEOUT_O is not set.
- Divider, per channel:
  - Active only while nRST_O[k]=1 and EN_I[k]=1.
  - P = DIV_I[k], with 0 treated as 1.
  - The counter is 0 in the release cycle and counts 0..P-1.
  - CLK_EN_O[k]=1 in the cycle the counter == P-1. At the following edge the counter wraps to 0 and CLK_O[k] toggles.
  - Resulting periods: strobe every P cycles; CLK_O period is 2P.
  - P is latched at release and at each wrap. A mid-period DIV_I change takes effect after the current wrap.
  - EN_I[k]=0: the counter and CLK_O[k] hold, and CLK_EN_O[k]=0. Re-enabling resumes from the held count.
  - When nRST_O[k]=0: the counter, CLK_O[k] and the latched P are cleared.
- Widths:
  - Divider counters are DIV_W bits.
  - The timeout counter is TO_W bits and never wraps, because expiry is detected first.
  - Stagger counter width = clog2(RST_HOLD + (N_CH-1)*STAGGER + 1).
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package/include clk_rst_seq_pkg:
  - State encodings S_ASSERT=2'd0, S_RELEASE=2'd1, S_RUN=2'd2, S_DONE=2'd3.
  - clog2 function.
- Sub-module clk_div_ch:
  - One divider channel: counter, P latch, strobe, toggle.
  - Instantiated N_CH times via generate.
- The FSM, release sequencer and watchdog stay in the top level.

Test Plan (N_CH=4, RST_HOLD=8, STAGGER=2, DIV_I={4,3,2,1} for ch3..ch0, EN_I=4'hF, TIMEOUT_I=0):
1. Release RST_I at cycle 0.
   - nRST_O rises on ch0/1/2/3 at cycles 8/10/12/14.
   - READY_O=1 at cycle 14; all outputs are at reset values before cycle 8.
2. Divider timing, same config:
   - ch0 (P=1) strobes every cycle from cycle 8, with CLK_O[0] toggling each cycle.
   - ch3 (P=4) first strobe at cycle 17, then cycles 21, 25; CLK_O[3] period 8.
3. TIMEOUT_I=100, release at cycle 0.
   - S_RUN entered at cycle 14; S_DONE at cycle 114.
   - TIMEOUT_O=1 and all nRST_O=0 from cycle 114; TIMEOUT_O stays 1 after a later SRST_REQ_I.
4. Pulse SRST_REQ_I for one cycle at cycle 11 (ch0, ch1 released).
   - All nRST_O=0 from cycle 12; the hold restarts, with ch0 released at cycle 20 and READY_O=1 at cycle 26.
5. Change DIV_I ch3 from 4 to 2 at cycle 18.
   - The next ch3 strobe is still at 21, then 23, 25.
   - Drop EN_I[3] for cycles 26-29: no strobes, CLK_O[3] frozen, and the strobe resumes at 31.
6. RST_I=1 and SRST_REQ_I=1 together mid-S_RUN, with timeout expiry coinciding with SRST_REQ_I in a second run.
   - In the first case, all outputs take reset values next cycle and TIMEOUT_O=0.
   - In the second run, the block is in S_ASSERT with TIMEOUT_O=0.
